// File: rtl/mure_uop_reader.sv
// Read side of the MURE trace connector: pairs uop FIFO entries with common FIFO
// entries (exceptions, interrupts, returns) and emits one registered packet per uop.
module mure_uop_reader #(
`ifdef TRDB_ARCH64
  parameter int XLEN = 64,
`else
  parameter int XLEN = 32,
`endif
  parameter int CAUSE_LEN = 5,
  parameter int PRIV_LEN = 2,
  parameter int ITYPE_LEN = 3,
  parameter int INST_LEN = 32,
  parameter int IRETIRE_LEN = 32,
  parameter int COMMON_TIMEOUT = 16,
  parameter logic [PRIV_LEN-1:0] PRIV_RESET = PRIV_LEN'(3)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      uop_empty_i,
  input  logic [ITYPE_LEN+INST_LEN+IRETIRE_LEN:0]   uop_data_i,
  output logic                                      uop_pop_o,
  input  logic                                      common_empty_i,
  input  logic [CAUSE_LEN+XLEN+PRIV_LEN-1:0]        common_data_i,
  output logic                                      common_pop_o,
  output logic                                      valid_o,
  input  logic                                      ready_i,
  output logic [ITYPE_LEN-1:0]                      itype_o,
  output logic [INST_LEN-1:0]                       iaddr_o,
  output logic [IRETIRE_LEN-1:0]                    iretire_o,
  output logic                                      ilastsize_o,
  output logic [CAUSE_LEN-1:0]                      cause_o,
  output logic [XLEN-1:0]                           tval_o,
  output logic [PRIV_LEN-1:0]                       priv_o,
  output logic                                      common_miss_o
);

  // Handshake: a packet transfers on any cycle with valid_o && ready_i; while
  // valid_o is high and ready_i low every packet output holds its value.

  localparam int CNT_W = $clog2(COMMON_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(COMMON_TIMEOUT - 1);

  // itype_e values that carry a common entry (STD=0 NTB=4 TB=5 UIJ=6 do not)
  localparam logic [ITYPE_LEN-1:0] ITYPE_EXC  = ITYPE_LEN'(1);
  localparam logic [ITYPE_LEN-1:0] ITYPE_INT  = ITYPE_LEN'(2);
  localparam logic [ITYPE_LEN-1:0] ITYPE_ERET = ITYPE_LEN'(3);

  typedef struct packed {
    logic [ITYPE_LEN-1:0]   itype;
    logic [INST_LEN-1:0]    iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
  } uop_entry_s;

  typedef struct packed {
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } common_entry_s;

  typedef enum logic {IDLE, WAIT_COMMON} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [PRIV_LEN-1:0] priv_q;
  uop_entry_s        uop_head;
  common_entry_s     common_head;
  logic              needs_common;
  logic              slot_free;
  logic              timeout_pop;

  assign uop_head     = uop_data_i;
  assign common_head  = common_data_i;
  assign needs_common = (uop_head.itype == ITYPE_EXC) || (uop_head.itype == ITYPE_INT) ||
                        (uop_head.itype == ITYPE_ERET);
  assign slot_free    = !valid_o || ready_i;

  // State register; wait_cnt_q saturates so a long backpressured wait never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE)
        wait_cnt_q <= '0;
      else if (wait_cnt_q != '1)
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rst_i && slot_free && !uop_empty_i && needs_common && common_empty_i)
          state_d = WAIT_COMMON;
      end
      WAIT_COMMON: begin
        if (uop_pop_o)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pairing has priority over the timeout, also once a stalled slot frees up.
  always_comb begin
    uop_pop_o    = 1'b0;
    common_pop_o = 1'b0;
    timeout_pop  = 1'b0;
    if (!rst_i && slot_free && !uop_empty_i) begin
      case (state_q)
        IDLE: begin
          if (!needs_common) begin
            uop_pop_o = 1'b1;
          end else if (!common_empty_i) begin
            uop_pop_o    = 1'b1;
            common_pop_o = 1'b1;
          end
        end
        WAIT_COMMON: begin
          if (!common_empty_i) begin
            uop_pop_o    = 1'b1;
            common_pop_o = 1'b1;
          end else if (wait_cnt_q >= TIMEOUT_LAST) begin
            uop_pop_o   = 1'b1;
            timeout_pop = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o       <= 1'b0;
      itype_o       <= '0;
      iaddr_o       <= '0;
      iretire_o     <= '0;
      ilastsize_o   <= 1'b0;
      cause_o       <= '0;
      tval_o        <= '0;
      priv_o        <= '0;
      priv_q        <= PRIV_RESET;
      common_miss_o <= 1'b0;
    end else begin
      if (uop_pop_o) begin
        valid_o     <= 1'b1;
        itype_o     <= uop_head.itype;
        iaddr_o     <= uop_head.iaddr;
        iretire_o   <= uop_head.iretire;
        ilastsize_o <= uop_head.ilastsize;
        if (common_pop_o) begin
          cause_o <= common_head.cause;
          tval_o  <= common_head.tval;
          priv_o  <= common_head.priv;
          priv_q  <= common_head.priv;
        end else begin
          cause_o <= '0;
          tval_o  <= '0;
          priv_o  <= priv_q;
        end
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
      if (timeout_pop)
        common_miss_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mure_uop_reader.sv
// Bench for mure_uop_reader: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the FIFOs and the output packet.
module tb_mure_uop_reader;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [2:0]  itype;
    logic [31:0] iaddr;
    logic [31:0] iretire;
    logic        ilastsize;
  } uop_t;

  typedef struct packed {
    logic [4:0]  cause;
    logic [31:0] tval;
    logic [1:0]  priv;
  } common_t;

  typedef struct packed {
    logic [2:0]  itype;
    logic [31:0] iaddr;
    logic [31:0] iretire;
    logic        ilastsize;
    logic [4:0]  cause;
    logic [31:0] tval;
    logic [1:0]  priv;
  } pkt_t;

  logic        clk;
  logic        rst_i;
  logic        uop_empty_i;
  logic [67:0] uop_data_i;
  logic        uop_pop_o;
  logic        common_empty_i;
  logic [38:0] common_data_i;
  logic        common_pop_o;
  logic        valid_o;
  logic        ready_i;
  logic [2:0]  itype_o;
  logic [31:0] iaddr_o;
  logic [31:0] iretire_o;
  logic        ilastsize_o;
  logic [4:0]  cause_o;
  logic [31:0] tval_o;
  logic [1:0]  priv_o;
  logic        common_miss_o;

  mure_uop_reader #(
    .XLEN(32), .CAUSE_LEN(5), .PRIV_LEN(2), .ITYPE_LEN(3), .INST_LEN(32),
    .IRETIRE_LEN(32), .COMMON_TIMEOUT(TIMEOUT), .PRIV_RESET(2'b11)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .uop_empty_i(uop_empty_i), .uop_data_i(uop_data_i), .uop_pop_o(uop_pop_o),
    .common_empty_i(common_empty_i), .common_data_i(common_data_i),
    .common_pop_o(common_pop_o),
    .valid_o(valid_o), .ready_i(ready_i),
    .itype_o(itype_o), .iaddr_o(iaddr_o), .iretire_o(iretire_o),
    .ilastsize_o(ilastsize_o), .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
    .common_miss_o(common_miss_o)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  // FIFO contents, reference model state and counters
  uop_t    uop_q[$];
  common_t common_q[$];
  int      errors = 0;
  int      checks = 0;
  int      cyc = 0;
  bit      m_valid;
  pkt_t    m_pkt;
  logic [1:0] m_priv;
  bit      m_miss;
  bit      m_waiting;
  int      wait_start;
  logic    last_up, last_cp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit needs(input logic [2:0] it);
    return (it == 3'd1) || (it == 3'd2) || (it == 3'd3);
  endfunction

  task automatic push_uop(input logic [2:0] it, input logic [31:0] addr);
    uop_t u;
    u.itype = it;
    u.iaddr = addr;
    u.iretire = addr[7:0] + 32'd2;
    u.ilastsize = addr[2];
    uop_q.push_back(u);
  endtask

  task automatic push_common(input logic [4:0] cause, input logic [31:0] tval,
                             input logic [1:0] priv);
    common_t c;
    c.cause = cause;
    c.tval = tval;
    c.priv = priv;
    common_q.push_back(c);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_pkt = '0;
    m_priv = 2'b11;
    m_miss = 1'b0;
    m_waiting = 1'b0;
    wait_start = 0;
  endtask

  // One clock cycle: drive FIFO heads, predict and check pops, update model, check outputs.
  task automatic cycle();
    bit e_up, e_cp, e_to, slot_free;
    uop_t u;
    common_t c;
    logic up_s, cp_s;
    uop_empty_i = (uop_q.size() == 0);
    uop_data_i = (uop_q.size() == 0) ? '0 : uop_q[0];
    common_empty_i = (common_q.size() == 0);
    common_data_i = (common_q.size() == 0) ? '0 : common_q[0];
    #1;
    e_up = 0; e_cp = 0; e_to = 0;
    slot_free = !m_valid || ready_i;
    u = (uop_q.size() == 0) ? '0 : uop_q[0];
    c = (common_q.size() == 0) ? '0 : common_q[0];
    if (!rst_i && slot_free && uop_q.size() > 0) begin
      if (!needs(u.itype)) begin
        e_up = 1;
      end else if (common_q.size() > 0) begin
        e_up = 1; e_cp = 1;
      end else if (m_waiting && (cyc - wait_start) >= TIMEOUT) begin
        e_up = 1; e_to = 1;
      end else if (!m_waiting) begin
        m_waiting = 1;
        wait_start = cyc;
      end
    end
    up_s = uop_pop_o;
    cp_s = common_pop_o;
    last_up = up_s;
    last_cp = cp_s;
    chk("uop_pop", 64'(up_s), 64'(e_up));
    chk("common_pop", 64'(cp_s), 64'(e_cp));
    @(posedge clk);
    if (rst_i) begin
      model_reset();
      uop_q.delete();
      common_q.delete();
    end else begin
      if (e_up) begin
        m_valid = 1;
        m_pkt.itype = u.itype;
        m_pkt.iaddr = u.iaddr;
        m_pkt.iretire = u.iretire;
        m_pkt.ilastsize = u.ilastsize;
        m_pkt.cause = e_cp ? c.cause : 5'd0;
        m_pkt.tval = e_cp ? c.tval : 32'd0;
        m_pkt.priv = e_cp ? c.priv : m_priv;
        if (e_cp) m_priv = c.priv;
        if (e_to) m_miss = 1;
        m_waiting = 0;
      end else if (ready_i) begin
        m_valid = 0;
      end
      if (up_s === 1'b1 && uop_q.size() > 0) void'(uop_q.pop_front());
      if (cp_s === 1'b1 && common_q.size() > 0) void'(common_q.pop_front());
    end
    #1;
    chk("valid", 64'(valid_o), 64'(m_valid));
    chk("itype", 64'(itype_o), 64'(m_pkt.itype));
    chk("iaddr", 64'(iaddr_o), 64'(m_pkt.iaddr));
    chk("iretire", 64'(iretire_o), 64'(m_pkt.iretire));
    chk("ilastsize", 64'(ilastsize_o), 64'(m_pkt.ilastsize));
    chk("cause", 64'(cause_o), 64'(m_pkt.cause));
    chk("tval", 64'(tval_o), 64'(m_pkt.tval));
    chk("priv", 64'(priv_o), 64'(m_pkt.priv));
    chk("common_miss", 64'(common_miss_o), 64'(m_miss));
    @(negedge clk);
    cyc++;
  endtask

  // Directed steps followed by random traffic
  initial begin
    logic [31:0] held_addr;
    int entry;
    bit got;
    model_reset();
    rst_i = 1'b1;
    ready_i = 1'b0;
    uop_empty_i = 1'b1;
    uop_data_i = '0;
    common_empty_i = 1'b1;
    common_data_i = '0;
    cycle();
    cycle();
    chk("reset_valid", 64'(valid_o), 64'd0);
    chk("reset_miss", 64'(common_miss_o), 64'd0);
    rst_i = 1'b0;
    cycle();

    // back-to-back flow
    ready_i = 1'b1;
    push_uop(3'd0, 32'h8000_0000);
    push_uop(3'd5, 32'h8000_0010);
    push_uop(3'd4, 32'h8000_0020);
    cycle();
    chk("b2b_first_pop", 64'(last_up), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_valid", 64'(valid_o), 64'd1);
      chk("b2b_cause", 64'(cause_o), 64'd0);
      chk("b2b_priv", 64'(priv_o), 64'd3);
      cycle();
    end
    chk("b2b_valid_drop", 64'(valid_o), 64'd0);

    // backpressure with two uops queued
    ready_i = 1'b0;
    push_uop(3'd0, 32'h8000_0040);
    push_uop(3'd6, 32'h8000_0044);
    cycle();
    held_addr = iaddr_o;
    chk("bp_first_addr", 64'(held_addr), 64'h8000_0040);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("bp_no_pop", 64'(last_up), 64'd0);
      chk("bp_hold_valid", 64'(valid_o), 64'd1);
      chk("bp_hold_addr", 64'(iaddr_o), 64'(held_addr));
    end
    ready_i = 1'b1;
    cycle();
    chk("bp_release_pop", 64'(last_up), 64'd1);
    chk("bp_second_addr", 64'(iaddr_o), 64'h8000_0044);
    cycle();
    cycle();

    // paired exception, then STD inheriting its priv
    push_common(5'd2, 32'hDEAD_BEEF, 2'd0);
    push_uop(3'd1, 32'h8000_0100);
    push_uop(3'd0, 32'h8000_0104);
    cycle();
    chk("exc_uop_pop", 64'(last_up), 64'd1);
    chk("exc_common_pop", 64'(last_cp), 64'd1);
    chk("exc_cause", 64'(cause_o), 64'd2);
    chk("exc_tval", 64'(tval_o), 64'hDEAD_BEEF);
    chk("exc_priv", 64'(priv_o), 64'd0);
    cycle();
    chk("std_after_exc_priv", 64'(priv_o), 64'd0);
    cycle();
    cycle();

    // late common entry for an interrupt
    push_uop(3'd2, 32'h8000_0200);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("late_no_pop", 64'(last_up), 64'd0);
    end
    push_common(5'd11, 32'h0000_1234, 2'd3);
    cycle();
    chk("late_pair_pop", 64'(last_cp), 64'd1);
    chk("late_valid", 64'(valid_o), 64'd1);
    chk("late_cause", 64'(cause_o), 64'd11);
    chk("late_miss", 64'(common_miss_o), 64'd0);
    cycle();
    cycle();

    // timeout on an ERET with no common entry
    push_uop(3'd3, 32'h8000_0300);
    entry = cyc;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      if (valid_o === 1'b1) got = 1;
    end
    chk("timeout_seen", 64'(got), 64'd1);
    chk("timeout_latency", 64'(cyc - entry), 64'd17);
    chk("timeout_cause", 64'(cause_o), 64'd0);
    chk("timeout_priv", 64'(priv_o), 64'd3);
    chk("timeout_miss", 64'(common_miss_o), 64'd1);
    for (int i = 0; i < 3; i++) cycle();
    chk("miss_sticky", 64'(common_miss_o), 64'd1);

    // reset in the middle of a wait
    push_common(5'd1, 32'h0000_0005, 2'd1);
    push_uop(3'd1, 32'h8000_0400);
    cycle();
    cycle();
    push_uop(3'd2, 32'h8000_0410);
    for (int i = 0; i < 3; i++) cycle();
    rst_i = 1'b1;
    cycle();
    chk("rst_no_uop_pop", 64'(last_up), 64'd0);
    chk("rst_no_common_pop", 64'(last_cp), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_miss", 64'(common_miss_o), 64'd0);
    rst_i = 1'b0;
    push_uop(3'd0, 32'h8000_0500);
    cycle();
    chk("rst_std_valid", 64'(valid_o), 64'd1);
    chk("rst_std_priv", 64'(priv_o), 64'd3);
    cycle();

    // random traffic with plentiful common entries
    for (int i = 0; i < 400; i++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      if (uop_q.size() < 4 && $urandom_range(0, 1) == 1)
        push_uop(3'($urandom_range(0, 6)), $urandom);
      if (common_q.size() < 3 && $urandom_range(0, 3) == 0)
        push_common(5'($urandom_range(0, 31)), $urandom, 2'($urandom_range(0, 3)));
      cycle();
    end

    // random traffic with scarce common entries, forcing timeouts under backpressure
    for (int i = 0; i < 400; i++) begin
      ready_i = ($urandom_range(0, 2) != 0);
      if (uop_q.size() < 3 && $urandom_range(0, 2) == 0)
        push_uop(3'($urandom_range(0, 6)), $urandom);
      if (common_q.size() < 2 && $urandom_range(0, 39) == 0)
        push_common(5'($urandom_range(0, 31)), $urandom, 2'($urandom_range(0, 3)));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
